gmem_addr_arbiter: RTL and testbench



---
 rtl/gmem_addr_arbiter_pkg.sv | 21 ++
 rtl/gmem_addr_arbiter_rr_arbiter.sv | 27 ++
 rtl/gmem_addr_arbiter.sv | 105 ++++++++++
 tb/tb_gmem_addr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gmem_addr_arbiter_pkg.sv
// Shared global-memory address definitions: default widths and the window
// relocation arithmetic used by every address slicer in the gmem path.
package gmem_pkg;
  localparam int FULL_ADDR_W   = 64;
  localparam int ACCESS_ADDR_W = 29;
  localparam int LEN_W         = 8;
  localparam int MAX_ADDR_W    = 64;

  function automatic int msb_width(input int full_w, input int access_w);
    return full_w - access_w;
  endfunction

  // {msbs, addr[access_w-1:0]} computed at the widest supported address width
  function automatic logic [MAX_ADDR_W-1:0] relocate(input logic [MAX_ADDR_W-1:0] msbs,
                                                     input logic [MAX_ADDR_W-1:0] addr,
                                                     input int                    access_w);
    logic [MAX_ADDR_W-1:0] low_mask;
    low_mask = (MAX_ADDR_W'(1) << access_w) - MAX_ADDR_W'(1);
    return (msbs << access_w) | (addr & low_mask);
  endfunction
endpackage

// File: rtl/gmem_addr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... modulo N and
// returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [ID_WIDTH-1:0]  ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [ID_WIDTH-1:0]  gnt_idx_o,
  output logic                 any_o
);
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      int cand;
      cand = (int'(ptr_i) + i) % NUM_PORTS;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = ID_WIDTH'(cand);
      end
    end
  end
endmodule

// File: rtl/gmem_addr_arbiter.sv
// Round-robin share of one gmem address channel; each grant is relocated into
// its port's base window and issued through a single registered slot.
module gmem_addr_arbiter
  import gmem_pkg::*;
#(
  parameter int FULL_ADDR_WIDTH   = FULL_ADDR_W,
  parameter int ACCESS_ADDR_WIDTH = ACCESS_ADDR_W,
  parameter int NUM_PORTS         = 4,
  parameter int LEN_WIDTH         = LEN_W,
  parameter int ID_WIDTH          = $clog2(NUM_PORTS)
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_cfg_we,
  input  logic [ID_WIDTH-1:0]                        i_cfg_idx,
  input  logic [FULL_ADDR_WIDTH-ACCESS_ADDR_WIDTH-1:0] i_cfg_msbs,
  input  logic [NUM_PORTS-1:0]                       i_req_valid,
  input  logic [NUM_PORTS*FULL_ADDR_WIDTH-1:0]       i_req_addr,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]             i_req_len,
  output logic [NUM_PORTS-1:0]                       o_req_ready,
  output logic                                       o_gmem_valid,
  output logic [FULL_ADDR_WIDTH-1:0]                 o_gmem_addr,
  output logic [LEN_WIDTH-1:0]                       o_gmem_len,
  output logic [ID_WIDTH-1:0]                        o_gmem_id,
  input  logic                                       i_gmem_ready
);
  localparam int MSB_WIDTH = msb_width(FULL_ADDR_WIDTH, ACCESS_ADDR_WIDTH);

  logic [NUM_PORTS-1:0][MSB_WIDTH-1:0] win_q;
  logic [ID_WIDTH-1:0]        ptr_q, ptr_d;
  logic                       valid_q, valid_d;
  logic [FULL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [ID_WIDTH-1:0]        id_q, id_d;

  logic [NUM_PORTS-1:0]       gnt;
  logic [ID_WIDTH-1:0]        gnt_idx;
  logic                       any_req;
  logic                       slot_free;
  logic [MAX_ADDR_W-1:0]      reloc;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .ID_WIDTH(ID_WIDTH)) u_rr (
    .req_i     (i_req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_req)
  );

  assign slot_free   = !valid_q || i_gmem_ready;
  assign o_req_ready = slot_free ? gnt : '0;

  // Window read here is the registered value, so a same-cycle cfg write is not seen
  assign reloc = relocate(MAX_ADDR_W'(win_q[gnt_idx]),
                          MAX_ADDR_W'(i_req_addr[int'(gnt_idx)*FULL_ADDR_WIDTH +: FULL_ADDR_WIDTH]),
                          ACCESS_ADDR_WIDTH);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (slot_free) begin
      if (any_req) begin
        valid_d = 1'b1;
        addr_d  = reloc[FULL_ADDR_WIDTH-1:0];
        len_d   = i_req_len[int'(gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
        id_d    = gnt_idx;
        ptr_d   = gnt_idx;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      ptr_q   <= ID_WIDTH'(NUM_PORTS-1);
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_q <= '0;
    end else if (i_cfg_we && (int'(i_cfg_idx) < NUM_PORTS)) begin
      win_q[i_cfg_idx] <= i_cfg_msbs;
    end
  end

  assign o_gmem_valid = valid_q;
  assign o_gmem_addr  = addr_q;
  assign o_gmem_len   = len_q;
  assign o_gmem_id    = id_q;
endmodule

// File: tb/tb_gmem_addr_arbiter.sv
// Directed bench: a 4-port arbiter for the main scenarios plus a 5-port
// instance where an out-of-range config index is representable.
module tb_gmem_addr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 4-port instance
  logic         cfg_we;
  logic [1:0]   cfg_idx;
  logic [34:0]  cfg_msbs;
  logic [3:0]   rq_valid;
  logic [255:0] rq_addr;
  logic [31:0]  rq_len;
  logic [3:0]   rq_ready;
  logic         g_valid;
  logic [63:0]  g_addr;
  logic [7:0]   g_len;
  logic [1:0]   g_id;
  logic         g_ready;

  gmem_addr_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_msbs(cfg_msbs),
    .i_req_valid(rq_valid), .i_req_addr(rq_addr), .i_req_len(rq_len),
    .o_req_ready(rq_ready),
    .o_gmem_valid(g_valid), .o_gmem_addr(g_addr), .o_gmem_len(g_len), .o_gmem_id(g_id),
    .i_gmem_ready(g_ready)
  );

  // 5-port instance
  logic         cfg5_we;
  logic [2:0]   cfg5_idx;
  logic [34:0]  cfg5_msbs;
  logic [4:0]   rq5_valid;
  logic [319:0] rq5_addr;
  logic [39:0]  rq5_len;
  logic [4:0]   rq5_ready;
  logic         g5_valid;
  logic [63:0]  g5_addr;
  logic [7:0]   g5_len;
  logic [2:0]   g5_id;
  logic         g5_ready;

  gmem_addr_arbiter #(.NUM_PORTS(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_we(cfg5_we), .i_cfg_idx(cfg5_idx), .i_cfg_msbs(cfg5_msbs),
    .i_req_valid(rq5_valid), .i_req_addr(rq5_addr), .i_req_len(rq5_len),
    .o_req_ready(rq5_ready),
    .o_gmem_valid(g5_valid), .o_gmem_addr(g5_addr), .o_gmem_len(g5_len), .o_gmem_id(g5_id),
    .i_gmem_ready(g5_ready)
  );

  task automatic test_reset();
    cfg_we = 0; cfg_idx = 0; cfg_msbs = 0; rq_valid = 0; rq_addr = 0; rq_len = 0; g_ready = 1;
    cfg5_we = 0; cfg5_idx = 0; cfg5_msbs = 0; rq5_valid = 0; rq5_addr = 0; rq5_len = 0; g5_ready = 1;
    rst_n = 0;
    #1;
    n_cmp++; if (g_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", g_valid); end
    n_cmp++; if (g_addr !== 64'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", g_addr); end
    n_cmp++; if (g_len !== 8'h0 || g_id !== 2'd0) begin n_err++; $display("FAIL reset_len_id got=%h/%0d exp=0/0", g_len, g_id); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++; if (rq_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", rq_ready); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      rq_addr[p*64 +: 64] = {32'hDEAD_0000, 32'(p*16)};
      rq_len[p*8 +: 8]    = 8'(p + 8);
    end
    rq_valid = 4'b1111; g_ready = 1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_id = 2'(k % 4);
      n_cmp++; if (rq_ready !== (4'b0001 << exp_id)) begin n_err++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, rq_ready, 4'b0001 << exp_id); end
      if (k > 0) begin
        n_cmp++; if (g_valid !== 1'b1 || g_id !== 2'((k - 1) % 4)) begin n_err++; $display("FAIL rr_id k=%0d got=%0b/%0d exp=1/%0d", k, g_valid, g_id, (k - 1) % 4); end
      end
    end
    @(negedge clk);
    rq_valid = 0;
    #1;
    n_cmp++; if (g_id !== 2'd1 || g_addr !== 64'h10 || g_len !== 8'd9) begin n_err++; $display("FAIL rr_last got=%0d/%h/%0d exp=1/10/9", g_id, g_addr, g_len); end
  endtask

  task automatic test_relocate();
    @(negedge clk);
    cfg_we = 1; cfg_idx = 2'd1; cfg_msbs = 35'h1;
    @(negedge clk);
    cfg_we = 0;
    rq_addr[1*64 +: 64] = 64'hFFFF_0000_1234_5678;
    rq_len[1*8 +: 8] = 8'd3;
    rq_valid = 4'b0010;
    #1;
    n_cmp++; if (rq_ready !== 4'b0010) begin n_err++; $display("FAIL reloc_ready got=%b exp=0010", rq_ready); end
    @(negedge clk);
    rq_valid = 0;
    #1;
    n_cmp++; if (g_valid !== 1'b1 || g_addr !== 64'h0000_0000_3234_5678) begin n_err++; $display("FAIL reloc_addr got=%0b/%h exp=1/0000000032345678", g_valid, g_addr); end
    n_cmp++; if (g_len !== 8'd3 || g_id !== 2'd1) begin n_err++; $display("FAIL reloc_len_id got=%0d/%0d exp=3/1", g_len, g_id); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    rq_addr[0*64 +: 64] = 64'hABCD_0000_0000_1000;
    rq_len[0*8 +: 8] = 8'd5;
    rq_valid = 4'b0001; g_ready = 1;
    #1;
    n_cmp++; if (rq_ready !== 4'b0001) begin n_err++; $display("FAIL stall_first_ready got=%b exp=0001", rq_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        g_ready = 0;
        rq_addr[2*64 +: 64] = 64'h0000_0000_1FFF_FFFF; rq_len[2*8 +: 8] = 8'd7;
        rq_addr[3*64 +: 64] = 64'h0000_0000_0000_0300; rq_len[3*8 +: 8] = 8'd1;
        rq_valid = 4'b1100;
      end
      #1;
      n_cmp++; if (rq_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready i=%0d got=%b exp=0000", i, rq_ready); end
      n_cmp++; if (g_valid !== 1'b1 || g_id !== 2'd0 || g_len !== 8'd5 || g_addr !== 64'h1000)
        begin n_err++; $display("FAIL stall_hold i=%0d got=%0b/%0d/%0d/%h exp=1/0/5/1000", i, g_valid, g_id, g_len, g_addr); end
    end
    @(negedge clk);
    g_ready = 1;
    #1;
    n_cmp++; if (rq_ready !== 4'b0100) begin n_err++; $display("FAIL stall_release_ready got=%b exp=0100", rq_ready); end
    @(negedge clk);
    rq_valid = 0;
    #1;
    n_cmp++; if (g_valid !== 1'b1 || g_id !== 2'd2 || g_len !== 8'd7 || g_addr !== 64'h1FFF_FFFF)
      begin n_err++; $display("FAIL stall_issue got=%0b/%0d/%0d/%h exp=1/2/7/1fffffff", g_valid, g_id, g_len, g_addr); end
  endtask

  task automatic test_cfg_same_cycle();
    @(negedge clk);
    cfg_we = 1; cfg_idx = 2'd2; cfg_msbs = 35'h7;
    rq_addr[2*64 +: 64] = 64'h40; rq_len[2*8 +: 8] = 8'd2;
    rq_valid = 4'b0100;
    #1;
    n_cmp++; if (rq_ready !== 4'b0100) begin n_err++; $display("FAIL cfgsc_ready got=%b exp=0100", rq_ready); end
    @(negedge clk);
    cfg_we = 0;
    #1;
    n_cmp++; if (g_addr !== 64'h40 || g_id !== 2'd2) begin n_err++; $display("FAIL cfgsc_old got=%h/%0d exp=40/2", g_addr, g_id); end
    rq_addr[2*64 +: 64] = 64'h80;
    #1;
    n_cmp++; if (rq_ready !== 4'b0100) begin n_err++; $display("FAIL cfgsc_ready2 got=%b exp=0100", rq_ready); end
    @(negedge clk);
    rq_valid = 0;
    #1;
    n_cmp++; if (g_addr !== 64'hE000_0080 || g_id !== 2'd2) begin n_err++; $display("FAIL cfgsc_new got=%h/%0d exp=e0000080/2", g_addr, g_id); end
  endtask

  task automatic test_drain_and_idx_range();
    logic [63:0] exp_a;
    @(negedge clk);
    #1;
    n_cmp++; if (g_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got=%0b exp=0", g_valid); end
    n_cmp++; if (rq_ready !== 4'b0000) begin n_err++; $display("FAIL drain_ready got=%b exp=0000", rq_ready); end
    cfg5_we = 1; cfg5_idx = 3'd5; cfg5_msbs = 35'h3;
    @(negedge clk);
    cfg5_idx = 3'd4; cfg5_msbs = 35'h2;
    @(negedge clk);
    cfg5_we = 0;
    for (int k = 0; k < 5; k++) begin
      rq5_addr[k*64 +: 64] = 64'hFFFF_FFFF_0000_0100 + 64'(k);
      rq5_valid = 5'b00001 << k;
      @(negedge clk);
      #1;
      exp_a = (k == 4) ? 64'h4000_0104 : 64'h100 + 64'(k);
      n_cmp++; if (g5_valid !== 1'b1 || g5_addr !== exp_a || g5_id !== 3'(k))
        begin n_err++; $display("FAIL idx_range k=%0d got=%0b/%h/%0d exp=1/%h/%0d", k, g5_valid, g5_addr, g5_id, exp_a, k); end
    end
    rq5_valid = 0;
    @(negedge clk);
    #1;
    n_cmp++; if (g5_valid !== 1'b0) begin n_err++; $display("FAIL idx_range_drain got=%0b exp=0", g5_valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    for (int p = 0; p < 4; p++) rq_addr[p*64 +: 64] = 64'h5000 + 64'(p);
    rq_valid = 4'b1111; g_ready = 1;
    @(negedge clk);
    #1;
    n_cmp++; if (g_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre got=%0b exp=1", g_valid); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if (g_valid !== 1'b0 || g_addr !== 64'h0 || g_id !== 2'd0)
      begin n_err++; $display("FAIL areset_now got=%0b/%h/%0d exp=0/0/0", g_valid, g_addr, g_id); end
    @(negedge clk);
    n_cmp++; if (g_valid !== 1'b0) begin n_err++; $display("FAIL areset_hold got=%0b exp=0", g_valid); end
    rst_n = 1;
    #1;
    n_cmp++; if (rq_ready !== 4'b0001) begin n_err++; $display("FAIL areset_first_ready got=%b exp=0001", rq_ready); end
    @(negedge clk);
    rq_valid = 4'b0010;
    #1;
    n_cmp++; if (g_valid !== 1'b1 || g_id !== 2'd0 || g_addr !== 64'h5000)
      begin n_err++; $display("FAIL areset_first got=%0b/%0d/%h exp=1/0/5000", g_valid, g_id, g_addr); end
    @(negedge clk);
    rq_valid = 0;
    #1;
    n_cmp++; if (g_id !== 2'd1 || g_addr !== 64'h5001)
      begin n_err++; $display("FAIL areset_win_clear got=%0d/%h exp=1/5001", g_id, g_addr); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_relocate();
    test_stall();
    test_cfg_same_cycle();
    test_drain_and_idx_range();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
